// File: rtl/req_ack_pkg.sv
// Shared types and default sizing for the req/ack source FIFO.
package req_ack_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int DEPTH_DEF      = 8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } state_t;

endpackage

// File: rtl/req_ack_source_if.sv
// Push side (wr_en/wr_data/full/level/overflow) and req/ack/dout link of req_ack_source.
interface req_ack_source_if
    import req_ack_pkg::*;
#(
    parameter int data_width = DATA_WIDTH_DEF,
    parameter int depth      = DEPTH_DEF
);
    localparam int LW = $clog2(depth) + 1;

    logic                  wr_en;
    logic [data_width-1:0] wr_data;
    logic                  full;
    logic [LW-1:0]         level;
    logic                  overflow;
    logic                  req;
    logic                  ack;
    logic [data_width-1:0] dout;

    // master: producer + consumer environment; slave: the FIFO source itself
    modport master (
        output wr_en, wr_data, req,
        input  full, level, overflow, ack, dout
    );

    modport slave (
        input  wr_en, wr_data, req,
        output full, level, overflow, ack, dout
    );

endinterface

// File: rtl/req_ack_fifo_mem.sv
// Register-array FIFO storage: write/read pointers, synchronous write, combinational head.
module req_ack_fifo_mem
    import req_ack_pkg::*;
#(
    parameter int data_width = DATA_WIDTH_DEF,
    parameter int depth      = DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [data_width-1:0] wr_data,
    output logic [data_width-1:0] head
);
    localparam int AW = $clog2(depth);

    logic [data_width-1:0] mem [depth];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;

    // depth is a power of two, so pointers wrap naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
        end
    end

    // Contents are don't-care after reset; no reset on the array.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/req_ack_source.sv
// Responder end of a req/ack link fed by a FIFO; one word per ack pulse.
// Optional REQ_ACK_SOURCE_STATS_EN adds ack_count/stall_count outputs.
module req_ack_source
    import req_ack_pkg::*;
#(
    parameter int data_width = DATA_WIDTH_DEF,
    parameter int depth      = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    req_ack_source_if.slave   bus
`ifdef REQ_ACK_SOURCE_STATS_EN
    ,
    output logic [31:0]       ack_count,
    output logic [31:0]       stall_count
`endif
);
    localparam int LW = $clog2(depth) + 1;

    state_t                state;
    logic [LW-1:0]         level_q;
    logic                  overflow_q;
    logic                  ack_q;
    logic [data_width-1:0] dout_q;
    logic [data_width-1:0] head;
    logic                  full_w;
    logic                  push;
    logic                  pop;
    logic                  stall;

    assign full_w = (level_q == LW'(depth));
    assign push   = bus.wr_en && !full_w;
    // Re-evaluation only in S_IDLE, so a held req cannot pop twice in a row.
    assign pop    = (state == S_IDLE) && bus.req && (level_q != '0);
    assign stall  = (state == S_IDLE) && bus.req && (level_q == '0);

    req_ack_fifo_mem #(
        .data_width (data_width),
        .depth      (depth)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wr_data (bus.wr_data),
        .head    (head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            ack_q      <= 1'b0;
            dout_q     <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        state  <= S_ACK;
                        ack_q  <= 1'b1;
                        dout_q <= head;
                    end
                end
                S_ACK: begin
                    state <= S_IDLE;
                    ack_q <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    ack_q <= 1'b0;
                end
            endcase

            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase

            // Dropped push is sticky even if a pop frees a slot on the same edge.
            if (bus.wr_en && full_w) overflow_q <= 1'b1;
        end
    end

    assign bus.ack      = ack_q;
    assign bus.dout     = dout_q;
    assign bus.level    = level_q;
    assign bus.full     = full_w;
    assign bus.overflow = overflow_q;

`ifdef REQ_ACK_SOURCE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_count   <= '0;
            stall_count <= '0;
        end else begin
            if (pop)   ack_count   <= ack_count + 32'd1;
            if (stall) stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_req_ack_source.sv
// Directed bench for req_ack_source; stats checks compile in with REQ_ACK_SOURCE_STATS_EN.
module tb_req_ack_source;
    import req_ack_pkg::*;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

`ifdef REQ_ACK_SOURCE_STATS_EN
    logic [31:0] ack_count;
    logic [31:0] stall_count;
`endif

    req_ack_source_if #(.data_width(32), .depth(8)) bus ();

    req_ack_source #(.data_width(32), .depth(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus)
`ifdef REQ_ACK_SOURCE_STATS_EN
        ,
        .ack_count   (ack_count),
        .stall_count (stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // basic flow table: inputs per cycle, expected state after the edge
    int t_we  [7] = '{1, 1, 1, 0, 0, 0, 0};
    int t_d   [7] = '{1, 2, 3, 0, 0, 0, 0};
    int t_ack [7] = '{0, 1, 0, 1, 0, 1, 0};
    int t_dout[7] = '{0, 1, 1, 2, 2, 3, 3};
    int t_lvl [7] = '{1, 1, 2, 1, 1, 0, 0};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        bus.wr_en = 1'b0;
        bus.req   = 1'b0;
        rst       = 1'b1;
        step();
        chk("rst_ack", bus.ack, 0);
        chk("rst_level", bus.level, 0);
        rst = 1'b0;
    endtask

    // Hold req until n words arrive (bounded), checking order and pulse spacing.
    task automatic drain_chk(input string tag, input int n, input int base);
        int   got;
        logic prev;
        got  = 0;
        prev = 1'b0;
        bus.req = 1'b1;
        for (int c = 0; c < 40; c++) begin
            step();
            if (bus.ack) begin
                chk({tag, "_dout"}, bus.dout, base + got);
                chk({tag, "_b2b"}, prev, 0);
                got++;
            end
            prev = bus.ack;
        end
        bus.req = 1'b0;
        chk({tag, "_count"}, got, n);
        chk({tag, "_level"}, bus.level, 0);
    endtask

    initial begin
        int pi, ci, cyc;
        logic [31:0] op_out;
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        bus.wr_en = 1'b0;
        bus.wr_data = '0;
        bus.req = 1'b0;
        step();
        step();
        chk("rst_ack", bus.ack, 0);
        chk("rst_dout", bus.dout, 0);
        chk("rst_level", bus.level, 0);
        chk("rst_full", bus.full, 0);
        chk("rst_ovf", bus.overflow, 0);
`ifdef REQ_ACK_SOURCE_STATS_EN
        chk("rst_ackcnt", ack_count, 0);
        chk("rst_stallcnt", stall_count, 0);
`endif
        rst = 1'b0;

        // push 1,2,3 with req held high
        bus.req = 1'b1;
        for (int k = 0; k < 7; k++) begin
            bus.wr_en   = t_we[k][0];
            bus.wr_data = t_d[k];
            step();
            chk("flow_ack", bus.ack, t_ack[k]);
            chk("flow_dout", bus.dout, t_dout[k]);
            chk("flow_level", bus.level, t_lvl[k]);
        end

        // req on empty FIFO for 10 cycles
        do_reset();
        bus.req = 1'b1;
        repeat (10) begin
            step();
            chk("stall_ack", bus.ack, 0);
            chk("stall_dout", bus.dout, 0);
        end
        bus.req = 1'b0;
        chk("stall_level", bus.level, 0);
`ifdef REQ_ACK_SOURCE_STATS_EN
        chk("stall_count", stall_count, 10);
`endif

        // overfill: 9 pushes into depth 8
        do_reset();
        bus.wr_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            bus.wr_data = i;
            step();
            if (i == 7) begin
                chk("fill_full8", bus.full, 1);
                chk("fill_ovf8", bus.overflow, 0);
            end
        end
        bus.wr_en = 1'b0;
        chk("ovf_full", bus.full, 1);
        chk("ovf_flag", bus.overflow, 1);
        chk("ovf_level", bus.level, 8);
        drain_chk("ovf_drain", 8, 0);

        // push on full coinciding with a pop
        do_reset();
        bus.wr_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.wr_data = 32'h10 + i;
            step();
        end
        chk("pp_full", bus.full, 1);
        bus.wr_data = 32'hAA;
        bus.req = 1'b1;
        step();
        bus.wr_en = 1'b0;
        bus.req = 1'b0;
        chk("pp_ack", bus.ack, 1);
        chk("pp_dout", bus.dout, 32'h10);
        chk("pp_level", bus.level, 7);
        chk("pp_ovf", bus.overflow, 1);
        drain_chk("pp_drain", 7, 32'h11);

        // reset in the middle of an ack
        do_reset();
        bus.wr_en = 1'b1;
        bus.wr_data = 32'h55;
        step();
        bus.wr_data = 32'h66;
        step();
        bus.wr_en = 1'b0;
        bus.req = 1'b1;
        step();
        chk("mid_ack", bus.ack, 1);
        chk("mid_dout", bus.dout, 32'h55);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_ack", bus.ack, 0);
        chk("mid_rst_level", bus.level, 0);
        chk("mid_rst_dout", bus.dout, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            step();
            chk("post_rst_ack", bus.ack, 0);
        end
        bus.wr_en = 1'b1;
        bus.wr_data = 32'h77;
        step();
        bus.wr_en = 1'b0;
        chk("post_push_ack", bus.ack, 0);
        chk("post_push_level", bus.level, 1);
        step();
        chk("post_ack", bus.ack, 1);
        chk("post_dout", bus.dout, 32'h77);
        chk("post_level", bus.level, 0);

        // addi(+2) operator consuming 5000 words
        do_reset();
        pi = 0;
        ci = 0;
        cyc = 0;
        bus.req = 1'b1;
        while (ci < 5000 && cyc < 20000) begin
            if (pi < 5000 && !bus.full) begin
                bus.wr_en = 1'b1;
                bus.wr_data = pi;
                pi++;
            end else begin
                bus.wr_en = 1'b0;
            end
            step();
            cyc++;
            if (bus.ack) begin
                op_out = bus.dout + 32'd2;
                chk("addi", op_out, ci + 2);
                ci++;
            end
        end
        bus.wr_en = 1'b0;
        bus.req = 1'b0;
        chk("addi_words", ci, 5000);
        chk("addi_ovf", bus.overflow, 0);
`ifdef REQ_ACK_SOURCE_STATS_EN
        chk("addi_ackcnt", ack_count, 5000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/req_ack_source.md
REQ_ACK_SOURCE -- requirements
Module: req_ack_source

Interface
REQ-001 Parameter data_width, default 32, width of every data word.
REQ-002 Parameter depth, default 8, FIFO entries; power of two, minimum 2.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port wr_en  input  1  push request from the upstream side.
REQ-006 Port wr_data  input  data_width  word to push.
REQ-007 Port full  output  1  high when level equals depth.
REQ-008 Port level  output  $clog2(depth)+1  number of stored words.
REQ-009 Port overflow  output  1  sticky flag; a push was dropped.
REQ-010 Port req  input  1  request from a downstream operator or consumer.
REQ-011 Port ack  output  1  registered one-cycle acknowledge pulse.
REQ-012 Port dout  output  data_width  delivered word; holds until the next ack.

Function
REQ-013 Block is the responder end of the req/ack link: an operator left port (req_l/ack_l) connects directly to req/ack/dout.
REQ-014 FSM states: S_IDLE and S_ACK; ack is high exactly in S_ACK.
REQ-015 S_IDLE -> S_ACK at an edge where req=1 and level>0; same edge: dout<=head word, pop head, level decrements.
REQ-016 S_ACK -> S_IDLE unconditionally at the next edge; ack is therefore a one-cycle pulse.
REQ-017 No ack is issued in two consecutive cycles; peak throughput is one word per 2 cycles.
REQ-018 req held high through S_ACK does not cause an extra pop; re-evaluation happens only in S_IDLE.
REQ-019 req=1 with level=0: stay in S_IDLE; ack stays 0; dout is unchanged.
REQ-020 Push at an edge where wr_en=1 and full=0: write wr_data at the tail; level increments.
REQ-021 Push while full=0 with a simultaneous pop: both take effect; level is unchanged.
REQ-022 Push at an edge where wr_en=1 and full=1: the word is dropped and overflow<=1, even if a pop occurs at the same edge.
REQ-023 Latency: a word pushed into an empty FIFO at edge t is first eligible for pop at edge t+1, so ack is high in the cycle after edge t+1.
REQ-024 Pointers are $clog2(depth) bits and wrap modulo depth; level distinguishes full from empty.
REQ-025 Words are delivered in strict push order.

Reset
REQ-026 While rst=1: ack=0, dout=0, level=0, full=0, overflow=0, FSM=S_IDLE, pointers=0; stored words are don't-care.
REQ-027 Reset asserted mid-handshake (S_ACK) forces ack=0 immediately and discards all buffered words.
REQ-028 The first ack after reset release requires at least one post-reset push.

Configuration
REQ-029 Macro REQ_ACK_SOURCE_STATS_EN adds output ports ack_count (32 bits) and stall_count (32 bits).
REQ-030 ack_count increments on every S_IDLE -> S_ACK transition.
REQ-031 stall_count increments on every S_IDLE cycle with req=1 and level=0.
REQ-032 Both counters reset to 0 and wrap modulo 2^32.
REQ-033 Without the macro these ports and counters are absent; all other behaviour is identical.

Structure
REQ-034 Shared package req_ack_pkg holds the FSM state typedef (S_IDLE, S_ACK) and the default data_width and depth constants.
REQ-035 Storage is a sub-module req_ack_fifo_mem: dual-pointer register array, synchronous write, combinational head read.
REQ-036 The FSM, level logic and the REQ_ACK_SOURCE_STATS_EN counters reside in req_ack_source.

Verification
REQ-037 Push 1,2,3 with req held high -> ack pulses in alternate cycles; dout=1,2,3 in order; level returns to 0.
REQ-038 req=1 with an empty FIFO for 10 cycles -> ack stays 0; stall_count=10 with the macro enabled.
REQ-039 depth=8: push 9 words 0..8 with req=0 -> full=1, overflow=1, level=8; draining yields 0..7 only.
REQ-040 Full FIFO with push of 0xAA on the same edge as a pop -> 0xAA dropped, overflow=1, level=7.
REQ-041 Assert rst while ack=1 -> ack=0 immediately, level=0; post-release req=1 yields no ack until a push.
REQ-042 Connect to a 1-input addi (immediate=2) operator and push 0..4999 -> operator output equals input+2 for every word; ack_count=5000.
